// File: rtl/cordic_chk_pkg.sv
// rtl/cordic_chk_pkg.sv - shared types and golden vector table for the CORDIC rotation result checker
package cordic_chk_pkg;

    localparam int GOLD_MAG  = 536870912;
    localparam int GOLD_C225 = 496004047;
    localparam int GOLD_S225 = 205451603;
    localparam int GOLD_C45  = 379625062;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } chkState_t;

    // Entry k is {x, y} of the radius-2^29 vector at 180deg + k*22.5deg
    localparam logic signed [31:0] GOLD_TABLE [16][2] = '{
        '{-GOLD_MAG,  0},
        '{-GOLD_C225, -GOLD_S225},
        '{-GOLD_C45,  -GOLD_C45},
        '{-GOLD_S225, -GOLD_C225},
        '{0,          -GOLD_MAG},
        '{GOLD_S225,  -GOLD_C225},
        '{GOLD_C45,   -GOLD_C45},
        '{GOLD_C225,  -GOLD_S225},
        '{GOLD_MAG,   0},
        '{GOLD_C225,  GOLD_S225},
        '{GOLD_C45,   GOLD_C45},
        '{GOLD_S225,  GOLD_C225},
        '{0,          GOLD_MAG},
        '{-GOLD_S225, GOLD_C225},
        '{-GOLD_C45,  GOLD_C45},
        '{-GOLD_C225, GOLD_S225}
    };

endpackage

// File: rtl/cordic_gold_rom.sv
// rtl/cordic_gold_rom.sv - combinational golden XN/YN lookup by sample index
module cordic_gold_rom
    import cordic_chk_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]              sample_idx,
    output logic signed [WIDTH-1:0] gold_x,
    output logic signed [WIDTH-1:0] gold_y
);

    always_comb begin
        gold_x = WIDTH'(GOLD_TABLE[sample_idx][0]);
        gold_y = WIDTH'(GOLD_TABLE[sample_idx][1]);
    end

endmodule

// File: rtl/cordic_rot_result_checker.sv
// rtl/cordic_rot_result_checker.sv - checks 16 CORDIC XN/YN samples against the golden circle with tolerance and timeout
module cordic_rot_result_checker
    import cordic_chk_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TOL     = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                    CLK,
    input  logic                    NGRST,
    input  logic                    start,
    input  logic                    din_valid,
    input  logic signed [WIDTH-1:0] xn,
    input  logic signed [WIDTH-1:0] yn,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [4:0]              err_cnt,
    output logic [3:0]              first_err_idx,
    output logic                    first_err_vld,
    output logic [3:0]              sample_idx
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic signed [WIDTH:0] TOL_POS = (WIDTH+1)'(TOL);
    localparam logic signed [WIDTH:0] TOL_NEG = -TOL_POS;

    chkState_t state, stateNext;
    logic [IDLE_W-1:0] idleCnt;
    logic drainCnt;
    logic accept, startOk, timeoutHit, mismatch;
    logic signed [WIDTH-1:0] goldX, goldY;
    logic s1Valid;
    logic [3:0] s1Idx;
    logic signed [WIDTH:0] dx, dy;

    cordic_gold_rom #(.WIDTH(WIDTH)) uGoldRom (
        .sample_idx(sample_idx),
        .gold_x    (goldX),
        .gold_y    (goldY)
    );

    always_ff @(posedge CLK or negedge NGRST) begin
        if (!NGRST) state <= ST_IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        accept     = 1'b0;
        startOk    = 1'b0;
        timeoutHit = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    startOk   = 1'b1;
                    stateNext = ST_RUN;
                end
            end
            ST_RUN: begin
                if (din_valid) begin
                    accept = 1'b1;
                    if (sample_idx == 4'd15) stateNext = ST_DRAIN;
                end else if (idleCnt == IDLE_W'(TIMEOUT - 1)) begin
                    timeoutHit = 1'b1;
                    stateNext  = ST_DRAIN;
                end
            end
            ST_DRAIN: if (drainCnt) stateNext = ST_DONE;
            default:  stateNext = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_RUN) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);
    assign mismatch = s1Valid && ((dx > TOL_POS) || (dx < TOL_NEG) ||
                                  (dy > TOL_POS) || (dy < TOL_NEG));

    always_ff @(posedge CLK or negedge NGRST) begin
        if (!NGRST) begin
            sample_idx    <= '0;
            idleCnt       <= '0;
            drainCnt      <= 1'b0;
            s1Valid       <= 1'b0;
            s1Idx         <= '0;
            dx            <= '0;
            dy            <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
            timeout       <= 1'b0;
            pass          <= 1'b0;
        end else begin
            // Stage 1: diffs one bit wider than the inputs so they cannot overflow
            s1Valid <= accept;
            if (accept) begin
                s1Idx      <= sample_idx;
                dx         <= (WIDTH+1)'(xn) - (WIDTH+1)'(goldX);
                dy         <= (WIDTH+1)'(yn) - (WIDTH+1)'(goldY);
                sample_idx <= sample_idx + 4'd1;
            end
            if (state == ST_RUN) idleCnt <= din_valid ? '0 : idleCnt + 1'b1;
            drainCnt <= (state == ST_DRAIN) ? ~drainCnt : 1'b0;
            if (timeoutHit) timeout <= 1'b1;
            // Stage 2: tally mismatches and remember the first one
            if (mismatch) begin
                if (err_cnt != 5'd16) err_cnt <= err_cnt + 5'd1;
                if (!first_err_vld) begin
                    first_err_idx <= s1Idx;
                    first_err_vld <= 1'b1;
                end
            end
            if (state == ST_DRAIN && stateNext == ST_DONE)
                pass <= !timeout && (err_cnt == 5'd0);
            if (startOk) begin
                sample_idx    <= '0;
                idleCnt       <= '0;
                drainCnt      <= 1'b0;
                err_cnt       <= '0;
                first_err_idx <= '0;
                first_err_vld <= 1'b0;
                timeout       <= 1'b0;
                pass          <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cordic_rot_result_checker.sv
// tb/tb_cordic_rot_result_checker.sv - directed self-checking bench for cordic_rot_result_checker
module tb_cordic_rot_result_checker;

    logic CLK = 1'b0;
    logic NGRST = 1'b0;
    logic start = 1'b0;
    logic din_valid = 1'b0;
    logic signed [31:0] xn = '0;
    logic signed [31:0] yn = '0;
    logic busy, done, pass, timeout, first_err_vld;
    logic [4:0] err_cnt;
    logic [3:0] first_err_idx, sample_idx;

    int nCmp = 0;
    int nErr = 0;

    int gx[16] = '{-536870912, -496004047, -379625062, -205451603,
                   0, 205451603, 379625062, 496004047,
                   536870912, 496004047, 379625062, 205451603,
                   0, -205451603, -379625062, -496004047};
    int gy[16] = '{0, -205451603, -379625062, -496004047,
                   -536870912, -496004047, -379625062, -205451603,
                   0, 205451603, 379625062, 496004047,
                   536870912, 496004047, 379625062, 205451603};

    cordic_rot_result_checker dut (
        .CLK          (CLK),
        .NGRST        (NGRST),
        .start        (start),
        .din_valid    (din_valid),
        .xn           (xn),
        .yn           (yn),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .timeout      (timeout),
        .err_cnt      (err_cnt),
        .first_err_idx(first_err_idx),
        .first_err_vld(first_err_vld),
        .sample_idx   (sample_idx)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_first_idx"}, first_err_idx, 0);
        check({tag, "_first_vld"}, first_err_vld, 0);
        check({tag, "_sample_idx"}, sample_idx, 0);
    endtask

    task automatic doStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic driveSample(input int k, input int xoff, input bit flipY);
        xn = gx[k] + xoff;
        yn = flipY ? -gy[k] : gy[k];
        din_valid = 1'b1;
    endtask

    task automatic feedRun(input int offIdx, input int xoff, input int flipA, input int flipB, input bit probe);
        for (int k = 0; k < 16; k++) begin
            driveSample(k, (k == offIdx) ? xoff : 0, (k == flipA) || (k == flipB));
            tick();
            if (probe && k == offIdx) check("latency_s1", err_cnt, 0);
            if (probe && k == offIdx + 1) check("latency_s2", err_cnt, 1);
        end
        din_valid = 1'b0;
    endtask

    task automatic expectDone(input string tag, input bit passExp, input int errExp,
                              input bit vldExp, input int idxExp, input bit toExp);
        check({tag, "_drain1_busy"}, busy, 1);
        tick();
        check({tag, "_drain2_busy"}, busy, 1);
        tick();
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 1);
        check({tag, "_pass"}, pass, passExp);
        check({tag, "_err_cnt"}, err_cnt, errExp);
        check({tag, "_first_vld"}, first_err_vld, vldExp);
        if (vldExp) check({tag, "_first_idx"}, first_err_idx, idxExp);
        check({tag, "_timeout"}, timeout, toExp);
    endtask

    initial begin
        repeat (3) tick();
        checkAllZero("reset");
        NGRST = 1'b1;
        tick();

        // Ideal back-to-back run
        doStart();
        check("ideal_busy_after_start", busy, 1);
        check("ideal_sample_idx_start", sample_idx, 0);
        feedRun(-1, 0, -1, -1, 1'b0);
        check("ideal_sample_idx_wrap", sample_idx, 0);
        expectDone("ideal", 1, 0, 0, 0, 0);

        // Tolerance edges on sample 3
        doStart();
        check("restart_done_cleared", done, 0);
        feedRun(3, 4, -1, -1, 1'b0);
        expectDone("tol_plus4", 1, 0, 0, 0, 0);
        doStart();
        feedRun(3, 5, -1, -1, 1'b1);
        expectDone("tol_plus5", 0, 1, 1, 3, 0);
        doStart();
        check("restart_err_cleared", err_cnt, 0);
        check("restart_vld_cleared", first_err_vld, 0);
        check("restart_pass_cleared", pass, 0);
        feedRun(10, -5, -1, -1, 1'b0);
        expectDone("tol_minus5", 0, 1, 1, 10, 0);
        doStart();
        feedRun(12, -4, -1, -1, 1'b0);
        expectDone("tol_minus4", 1, 0, 0, 0, 0);

        // Two sign-flipped YN samples
        doStart();
        feedRun(-1, 0, 5, 9, 1'b0);
        expectDone("multi_err", 0, 2, 1, 5, 0);

        // Sparse input with 100-cycle gaps
        doStart();
        for (int k = 0; k < 16; k++) begin
            driveSample(k, 0, 1'b0);
            tick();
            din_valid = 1'b0;
            if (k < 15) repeat (100) tick();
        end
        expectDone("sparse", 1, 0, 0, 0, 0);

        // Timeout after sample 7
        doStart();
        for (int k = 0; k < 8; k++) begin
            driveSample(k, 0, 1'b0);
            tick();
        end
        din_valid = 1'b0;
        repeat (1023) tick();
        check("timeout_not_yet", timeout, 0);
        check("timeout_sample_idx", sample_idx, 8);
        tick();
        check("timeout_set", timeout, 1);
        tick();
        check("timeout_drain_busy", busy, 1);
        tick();
        check("timeout_done", done, 1);
        check("timeout_pass", pass, 0);
        check("timeout_err_cnt", err_cnt, 0);
        doStart();
        check("restart_timeout_cleared", timeout, 0);

        // Asynchronous reset in the middle of a run with an error already counted
        for (int k = 0; k < 8; k++) begin
            driveSample(k, 0, k == 1);
            tick();
        end
        check("pre_reset_err_cnt", err_cnt, 1);
        driveSample(8, 0, 1'b0);
        #2 NGRST = 1'b0;
        #1;
        checkAllZero("async_reset");
        din_valid = 1'b0;
        repeat (2) tick();
        NGRST = 1'b1;
        tick();
        check("post_reset_idle", busy, 0);

        // din_valid while IDLE and in the start cycle, then start mid-RUN
        driveSample(0, 0, 1'b0);
        tick();
        check("idle_valid_sample_idx", sample_idx, 0);
        check("idle_valid_busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        din_valid = 1'b0;
        check("start_cycle_valid_sample_idx", sample_idx, 0);
        check("start_cycle_busy", busy, 1);
        for (int k = 0; k < 5; k++) begin
            driveSample(k, 0, 1'b0);
            tick();
        end
        din_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mid_run_start_sample_idx", sample_idx, 5);
        for (int k = 5; k < 16; k++) begin
            driveSample(k, 0, 1'b0);
            tick();
        end
        din_valid = 1'b0;
        expectDone("post_reset_run", 1, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
